l2_pmem_burst_adapter: RTL



---
 rtl/l2_pmem_burst_adapter_pkg.sv | 19 +
 rtl/l2_pmem_burst_adapter_buffer.sv | 65 ++++++
 rtl/l2_pmem_burst_adapter.sv | 117 +++++++++++
 3 files changed

// File: rtl/l2_pmem_burst_adapter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l2_pmem_adapter_types: shared state encoding and beat-count width   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package l2_pmem_adapter_types;

  localparam int unsigned NUM_BEATS = 4;
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_pmem_burst_adapter_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | burst_beat_buffer: read-line assembly, write-line beat select,      |
// | beat counter. Rev 1.0                                               |
// +--------------------------------------------------------------------+
module burst_beat_buffer
  import l2_pmem_adapter_types::*;
#(
  parameter int unsigned s_line = 256,
  parameter int unsigned s_beat = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rbeat_we_i,
  input  logic [s_beat-1:0] rbeat_data_i,
  input  logic              wline_load_i,
  input  logic [s_line-1:0] wline_data_i,
  input  logic              cnt_inc_i,
  input  logic              cnt_clr_i,
  output logic [s_line-1:0] rline_o,
  output logic [s_beat-1:0] wbeat_o,
  output logic              last_o
);

  localparam int unsigned NB = s_line / s_beat;

  logic [s_line-1:0] rline_q;
  logic [s_line-1:0] wline_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [s_beat-1:0] wbeats [NB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rline_q <= '0;
      wline_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (rbeat_we_i)
        rline_q[cnt_q*s_beat +: s_beat] <= rbeat_data_i;
      if (wline_load_i)
        wline_q <= wline_data_i;
      cnt_q <= cnt_d;
    end
  end

  // Counter wraps naturally to 0 after the last beat of a line.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)
      cnt_d = '0;
    else if (cnt_inc_i)
      cnt_d = cnt_q + 1'b1;
  end

  for (genvar b = 0; b < NB; b++) begin : g_beat
    assign wbeats[b] = wline_q[b*s_beat +: s_beat];
  end

  assign wbeat_o = wbeats[cnt_q];
  assign rline_o = rline_q;
  assign last_o  = (cnt_q == CNT_W'(NB - 1));

endmodule
`default_nettype wire

// File: rtl/l2_pmem_burst_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l2_pmem_burst_adapter: L2 line port to 4-beat 64-bit burst port     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module l2_pmem_burst_adapter
  import l2_pmem_adapter_types::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_beat   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       line_address,
  output logic [s_line-1:0] line_rdata,
  input  logic [s_line-1:0] line_wdata,
  input  logic              line_read,
  input  logic              line_write,
  output logic              line_resp,
  output logic [31:0]       burst_address,
  input  logic [s_beat-1:0] burst_rdata,
  output logic [s_beat-1:0] burst_wdata,
  output logic              burst_read,
  output logic              burst_write,
  input  logic              burst_resp
);

  adapter_state_t state_q;
  adapter_state_t state_d;
  logic [31:0]    addr_q;
  logic [31:0]    addr_d;
  logic           rbeat_we;
  logic           wline_load;
  logic           cnt_inc;
  logic           cnt_clr;
  logic           last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rbeat_we    = 1'b0;
    wline_load  = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    line_resp   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        // Write wins when both requests are presented together.
        if (line_write) begin
          addr_d     = {line_address[31:s_offset], {s_offset{1'b0}}};
          wline_load = 1'b1;
          state_d    = WRITE;
        end else if (line_read) begin
          addr_d  = {line_address[31:s_offset], {s_offset{1'b0}}};
          state_d = READ;
        end
      end
      READ: begin
        burst_read = 1'b1;
        if (burst_resp) begin
          rbeat_we = 1'b1;
          cnt_inc  = 1'b1;
          if (last_beat)
            state_d = DONE;
        end
      end
      WRITE: begin
        burst_write = 1'b1;
        if (burst_resp) begin
          cnt_inc = 1'b1;
          if (last_beat)
            state_d = DONE;
        end
      end
      DONE: begin
        line_resp = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  burst_beat_buffer #(
    .s_line (s_line),
    .s_beat (s_beat)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .rbeat_we_i   (rbeat_we),
    .rbeat_data_i (burst_rdata),
    .wline_load_i (wline_load),
    .wline_data_i (line_wdata),
    .cnt_inc_i    (cnt_inc),
    .cnt_clr_i    (cnt_clr),
    .rline_o      (line_rdata),
    .wbeat_o      (burst_wdata),
    .last_o       (last_beat)
  );

  assign burst_address = addr_q;

endmodule
`default_nettype wire
